// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter sharing one rstrb/wmask/rbusy memory port.
// Strobes are latched per port and replayed to memory one transaction at a time.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic                  p0_rstrb,
  input  logic [31:0]           p0_wdata,
  input  logic [3:0]            p0_wmask,
  output logic [31:0]           p0_rdata,
  output logic                  p0_rbusy,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic                  p1_rstrb,
  input  logic [31:0]           p1_wdata,
  input  logic [3:0]            p1_wmask,
  output logic [31:0]           p1_rdata,
  output logic                  p1_rbusy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rstrb,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rbusy,
  output logic                  grant,
  output logic                  proto_err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_W-1:0]     wdata;
    logic [MASK_W-1:0]     wmask;
  } req_t;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    ISSUE = 3'b010,
    WAIT  = 3'b100
  } state_t;

  state_t state_q, state_d;
  req_t   lat0, lat1, sel;
  logic   pend0, pend1, active;
  logic   req0, req1, busy0, busy1;
  logic   award, complete, win;

  assign req0  = p0_rstrb | (|p0_wmask);
  assign req1  = p1_rstrb | (|p1_wmask);
  // grant doubles as the owner of the in-flight transaction
  assign busy0 = pend0 | (active & ~grant);
  assign busy1 = pend1 | (active & grant);
  assign p0_rbusy = busy0;
  assign p1_rbusy = busy1;

  // Winner selection and next-state decode
  always_comb begin
    state_d  = state_q;
    award    = 1'b0;
    complete = 1'b0;
    win      = 1'b0;
    if (pend0 && pend1) begin
      win = (FIXED_PRIORITY != 0) ? 1'b0 : ~grant;
    end else begin
      win = ~pend0;
    end
    sel = win ? lat1 : lat0;
    case (state_q)
      IDLE: begin
        if (pend0 || pend1) begin
          award   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (!mem_rbusy) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Port 0 request latch; a strobe while busy is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend0 <= 1'b0;
      lat0  <= '0;
    end else if (req0 && !busy0) begin
      pend0 <= 1'b1;
      lat0  <= '{addr: p0_addr, wdata: p0_wdata, wmask: p0_wmask};
    end else if (award && !win) begin
      pend0 <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend1 <= 1'b0;
      lat1  <= '0;
    end else if (req1 && !busy1) begin
      pend1 <= 1'b1;
      lat1  <= '{addr: p1_addr, wdata: p1_wdata, wmask: p1_wmask};
    end else if (award && win) begin
      pend1 <= 1'b0;
    end
  end

  // Memory-side issue, completion capture and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      mem_rstrb <= 1'b0;
      grant     <= 1'b1;
      active    <= 1'b0;
      proto_err <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      if ((req0 && busy0) || (req1 && busy1)) proto_err <= 1'b1;
      if (award) begin
        mem_addr  <= sel.addr;
        mem_wdata <= sel.wdata;
        mem_wmask <= sel.wmask;
        mem_rstrb <= (sel.wmask == '0);
        grant     <= win;
        active    <= 1'b1;
      end else if (state_q == ISSUE) begin
        mem_rstrb <= 1'b0;
        mem_wmask <= '0;
      end
      if (complete) begin
        active <= 1'b0;
        if (grant) p1_rdata <= mem_rdata;
        else       p0_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: round-robin and fixed-priority instances
// driven from a shared cycle table, plus hand sequences for waits, errors and reset.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] p0_addr = '0, p1_addr = '0, p0_wdata = '0, p1_wdata = '0;
  logic        p0_rstrb = 1'b0, p1_rstrb = 1'b0;
  logic [3:0]  p0_wmask = '0, p1_wmask = '0;

  logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        p0_rbusy, p1_rbusy, mem_rstrb, mem_rbusy, grant, proto_err;
  logic [3:0]  mem_wmask;

  logic [31:0] fp_p0_rdata, fp_p1_rdata, fp_mem_addr, fp_mem_wdata, fp_mem_rdata;
  logic        fp_p0_rbusy, fp_p1_rbusy, fp_mem_rstrb, fp_grant, fp_proto_err;
  logic [3:0]  fp_mem_wmask;

  logic [31:0] key = 32'h1357_9BDF;
  int unsigned wait_n = 0;
  logic [3:0]  busy_cnt;
  int          n_acc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIORITY(0)) dut (
    .clk(clk), .reset(reset),
    .p0_addr(p0_addr), .p0_rstrb(p0_rstrb), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
    .p0_rdata(p0_rdata), .p0_rbusy(p0_rbusy),
    .p1_addr(p1_addr), .p1_rstrb(p1_rstrb), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
    .p1_rdata(p1_rdata), .p1_rbusy(p1_rbusy),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy),
    .grant(grant), .proto_err(proto_err)
  );

  mem_bus_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .reset(reset),
    .p0_addr(p0_addr), .p0_rstrb(p0_rstrb), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
    .p0_rdata(fp_p0_rdata), .p0_rbusy(fp_p0_rbusy),
    .p1_addr(p1_addr), .p1_rstrb(p1_rstrb), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
    .p1_rdata(fp_p1_rdata), .p1_rbusy(fp_p1_rbusy),
    .mem_addr(fp_mem_addr), .mem_rstrb(fp_mem_rstrb), .mem_wdata(fp_mem_wdata),
    .mem_wmask(fp_mem_wmask), .mem_rdata(fp_mem_rdata), .mem_rbusy(1'b0),
    .grant(fp_grant), .proto_err(fp_proto_err)
  );

  // Memory model: data is a function of address, busy for wait_n cycles after a strobe
  assign mem_rdata    = mem_addr ^ key;
  assign fp_mem_rdata = fp_mem_addr ^ key;
  assign mem_rbusy    = (busy_cnt != 4'd0);

  always @(posedge clk or posedge reset) begin
    if (reset) busy_cnt <= 4'd0;
    else if (mem_rstrb || (mem_wmask != 4'd0)) busy_cnt <= 4'(wait_n);
    else if (busy_cnt != 4'd0) busy_cnt <= busy_cnt - 4'd1;
  end

  always @(posedge clk) begin
    if (mem_rstrb || (mem_wmask != 4'd0)) n_acc <= n_acc + 1;
  end

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ key;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r0, input logic [3:0] m0, input logic [31:0] a0,
                        input logic r1, input logic [3:0] m1, input logic [31:0] a1,
                        input logic [31:0] d1);
    p0_rstrb = r0; p0_wmask = m0; p0_addr = a0; p0_wdata = 32'h0;
    p1_rstrb = r1; p1_wmask = m1; p1_addr = a1; p1_wdata = d1;
  endtask

  task automatic idle_in();
    set_in(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        r0;
    logic [31:0] a0;
    logic        r1;
    logic [31:0] a1;
    logic        b0, b1, mrs, g;
    logic [31:0] maddr, rd0, rd1;
    logic        fb0, fb1, fg;
  } vec_t;

  vec_t tbl [18];

  task automatic row(input int i, input logic r0, input logic [31:0] a0,
                     input logic r1, input logic [31:0] a1,
                     input logic b0, input logic b1, input logic mrs, input logic g,
                     input logic [31:0] maddr, input logic [31:0] rd0, input logic [31:0] rd1,
                     input logic fb0, input logic fb1, input logic fg);
    tbl[i] = '{r0: r0, a0: a0, r1: r1, a1: a1, b0: b0, b1: b1, mrs: mrs, g: g,
               maddr: maddr, rd0: rd0, rd1: rd1, fb0: fb0, fb1: fb1, fg: fg};
  endtask

  initial begin
    logic [31:0] d100, d104, d108, d200, d204;
    int acc0;
    d100 = dat(32'h100); d104 = dat(32'h104); d108 = dat(32'h108);
    d200 = dat(32'h200); d204 = dat(32'h204);

    // Contest after reset, a solo p0 read, then a second contest
    row( 0, 1, 32'h100, 1, 32'h200, 1, 1, 0, 1, 32'h0,   32'h0, 32'h0, 1, 1, 1);
    row( 1, 0, 32'h0,   0, 32'h0,   1, 1, 1, 0, 32'h100, 32'h0, 32'h0, 1, 1, 0);
    row( 2, 0, 32'h0,   0, 32'h0,   1, 1, 0, 0, 32'h100, 32'h0, 32'h0, 1, 1, 0);
    row( 3, 0, 32'h0,   0, 32'h0,   0, 1, 0, 0, 32'h100, d100,  32'h0, 0, 1, 0);
    row( 4, 0, 32'h0,   0, 32'h0,   0, 1, 1, 1, 32'h200, d100,  32'h0, 0, 1, 1);
    row( 5, 0, 32'h0,   0, 32'h0,   0, 1, 0, 1, 32'h200, d100,  32'h0, 0, 1, 1);
    row( 6, 0, 32'h0,   0, 32'h0,   0, 0, 0, 1, 32'h200, d100,  d200,  0, 0, 1);
    row( 7, 1, 32'h104, 0, 32'h0,   1, 0, 0, 1, 32'h200, d100,  d200,  1, 0, 1);
    row( 8, 0, 32'h0,   0, 32'h0,   1, 0, 1, 0, 32'h104, d100,  d200,  1, 0, 0);
    row( 9, 0, 32'h0,   0, 32'h0,   1, 0, 0, 0, 32'h104, d100,  d200,  1, 0, 0);
    row(10, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h104, d104,  d200,  0, 0, 0);
    row(11, 1, 32'h108, 1, 32'h204, 1, 1, 0, 0, 32'h104, d104,  d200,  1, 1, 0);
    row(12, 0, 32'h0,   0, 32'h0,   1, 1, 1, 1, 32'h204, d104,  d200,  1, 1, 0);
    row(13, 0, 32'h0,   0, 32'h0,   1, 1, 0, 1, 32'h204, d104,  d200,  1, 1, 0);
    row(14, 0, 32'h0,   0, 32'h0,   1, 0, 0, 1, 32'h204, d104,  d204,  0, 1, 0);
    row(15, 0, 32'h0,   0, 32'h0,   1, 0, 1, 0, 32'h108, d104,  d204,  0, 1, 1);
    row(16, 0, 32'h0,   0, 32'h0,   1, 0, 0, 0, 32'h108, d104,  d204,  0, 1, 1);
    row(17, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h108, d108,  d204,  0, 0, 1);

    // Single zero-wait read returning 0xDEADBEEF
    do_reset();
    chk("rst p0_rbusy", 32'(p0_rbusy), 32'h0);
    chk("rst p1_rbusy", 32'(p1_rbusy), 32'h0);
    chk("rst grant", 32'(grant), 32'h1);
    chk("rst proto_err", 32'(proto_err), 32'h0);
    chk("rst mem_rstrb", 32'(mem_rstrb), 32'h0);
    key = 32'hDEADBEEF ^ 32'h0081_0000;
    set_in(1'b1, 4'h0, 32'h0081_0000, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("rd T+1 p0_rbusy", 32'(p0_rbusy), 32'h1);
    chk("rd T+1 mem_rstrb", 32'(mem_rstrb), 32'h0);
    idle_in();
    tick();
    chk("rd T+2 mem_rstrb", 32'(mem_rstrb), 32'h1);
    chk("rd T+2 mem_addr", mem_addr, 32'h0081_0000);
    tick();
    chk("rd T+3 mem_rstrb", 32'(mem_rstrb), 32'h0);
    chk("rd T+3 p0_rbusy", 32'(p0_rbusy), 32'h1);
    tick();
    chk("rd T+4 p0_rbusy", 32'(p0_rbusy), 32'h0);
    chk("rd T+4 p0_rdata", p0_rdata, 32'hDEADBEEF);
    tick();
    chk("rd hold p0_rdata", p0_rdata, 32'hDEADBEEF);

    // Table-driven contention on both instances
    do_reset();
    key = 32'h1357_9BDF;
    for (int i = 0; i < 18; i++) begin
      set_in(tbl[i].r0, 4'h0, tbl[i].a0, tbl[i].r1, 4'h0, tbl[i].a1, 32'h0);
      tick();
      chk($sformatf("row%0d p0_rbusy", i), 32'(p0_rbusy), 32'(tbl[i].b0));
      chk($sformatf("row%0d p1_rbusy", i), 32'(p1_rbusy), 32'(tbl[i].b1));
      chk($sformatf("row%0d mem_rstrb", i), 32'(mem_rstrb), 32'(tbl[i].mrs));
      chk($sformatf("row%0d grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("row%0d mem_addr", i), mem_addr, tbl[i].maddr);
      chk($sformatf("row%0d p0_rdata", i), p0_rdata, tbl[i].rd0);
      chk($sformatf("row%0d p1_rdata", i), p1_rdata, tbl[i].rd1);
      chk($sformatf("row%0d fp p0_rbusy", i), 32'(fp_p0_rbusy), 32'(tbl[i].fb0));
      chk($sformatf("row%0d fp p1_rbusy", i), 32'(fp_p1_rbusy), 32'(tbl[i].fb1));
      chk($sformatf("row%0d fp grant", i), 32'(fp_grant), 32'(tbl[i].fg));
    end
    chk("tbl proto_err", 32'(proto_err), 32'h0);

    // Byte write on port 1 with three memory wait cycles
    do_reset();
    wait_n = 3;
    set_in(1'b0, 4'h0, 32'h0, 1'b0, 4'b0100, 32'h1002, 32'h00AB_0000);
    tick();
    chk("wr T+1 p1_rbusy", 32'(p1_rbusy), 32'h1);
    idle_in();
    tick();
    chk("wr issue mem_wmask", 32'(mem_wmask), 32'h4);
    chk("wr issue mem_rstrb", 32'(mem_rstrb), 32'h0);
    chk("wr issue mem_addr", mem_addr, 32'h1002);
    chk("wr issue mem_wdata", mem_wdata, 32'h00AB_0000);
    tick();
    chk("wr wait mem_wmask", 32'(mem_wmask), 32'h0);
    chk("wr wait mem_rbusy", 32'(mem_rbusy), 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("wr wait%0d mem_addr", k), mem_addr, 32'h1002);
      chk($sformatf("wr wait%0d mem_wdata", k), mem_wdata, 32'h00AB_0000);
      chk($sformatf("wr wait%0d p1_rbusy", k), 32'(p1_rbusy), 32'h1);
    end
    chk("wr mem_rbusy fallen", 32'(mem_rbusy), 32'h0);
    tick();
    chk("wr done p1_rbusy", 32'(p1_rbusy), 32'h0);
    wait_n = 0;

    // Duplicate strobes while busy, including on the completion edge
    do_reset();
    acc0 = n_acc;
    set_in(1'b1, 4'h0, 32'h40, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("pe first proto_err", 32'(proto_err), 32'h0);
    set_in(1'b1, 4'h0, 32'h44, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("pe dup proto_err", 32'(proto_err), 32'h1);
    chk("pe dup mem_addr", mem_addr, 32'h40);
    idle_in();
    tick();
    set_in(1'b1, 4'h0, 32'h48, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("pe done p0_rbusy", 32'(p0_rbusy), 32'h0);
    chk("pe done p0_rdata", p0_rdata, dat(32'h40));
    idle_in();
    repeat (4) tick();
    chk("pe access count", 32'(n_acc - acc0), 32'h1);
    chk("pe sticky proto_err", 32'(proto_err), 32'h1);
    chk("pe quiet p0_rbusy", 32'(p0_rbusy), 32'h0);

    // Asynchronous reset while memory is busy
    do_reset();
    set_in(1'b1, 4'h0, 32'h300, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    idle_in();
    repeat (3) tick();
    chk("ar pre p0_rdata", p0_rdata, dat(32'h300));
    wait_n = 6;
    set_in(1'b1, 4'h0, 32'h304, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    idle_in();
    tick();
    tick();
    chk("ar in-wait p0_rbusy", 32'(p0_rbusy), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    chk("ar p0_rbusy", 32'(p0_rbusy), 32'h0);
    chk("ar p1_rbusy", 32'(p1_rbusy), 32'h0);
    chk("ar mem_rstrb", 32'(mem_rstrb), 32'h0);
    chk("ar mem_wmask", 32'(mem_wmask), 32'h0);
    chk("ar mem_addr", mem_addr, 32'h0);
    chk("ar mem_wdata", mem_wdata, 32'h0);
    chk("ar p0_rdata", p0_rdata, 32'h0);
    chk("ar p1_rdata", p1_rdata, 32'h0);
    chk("ar grant", 32'(grant), 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_n = 0;
    set_in(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h500, 32'h0);
    tick();
    chk("ar p1 T+1 p1_rbusy", 32'(p1_rbusy), 32'h1);
    idle_in();
    tick();
    chk("ar p1 mem_addr", mem_addr, 32'h500);
    chk("ar p1 mem_rstrb", 32'(mem_rstrb), 32'h1);
    tick();
    tick();
    chk("ar p1 done p1_rbusy", 32'(p1_rbusy), 32'h0);
    chk("ar p1 p1_rdata", p1_rdata, dat(32'h500));
    chk("ar p1 p0_rbusy", 32'(p0_rbusy), 32'h0);
    chk("ar p1 grant", 32'(grant), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
